// File: rtl/ring_router_mc.sv
// ring_router_mc: NCHAN-channel debug ring stop with packet-atomic arbitration; RING_ROUTER_MC_BROADCAST_EN enables 16'hFFFF broadcast
module ring_router_mc #(
  parameter int NCHAN = 2,
  parameter int BUFFER_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           id,
  input  logic [NCHAN-1:0][17:0] ring_in,
  output logic [NCHAN-1:0]      ring_in_ready,
  output logic [NCHAN-1:0][17:0] ring_out,
  input  logic [NCHAN-1:0]      ring_out_ready,
  input  logic [17:0]           local_in,
  output logic                  local_in_ready,
  output logic [17:0]           local_out,
  input  logic                  local_out_ready
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  typedef enum logic [1:0] {
    IDLE,
    FWD,
    LOCAL
`ifdef RING_ROUTER_MC_BROADCAST_EN
    , BCAST
`endif
  } state_t;
  logic [NCHAN:0][17:0] in_f;
  logic [NCHAN:0][16:0] hd;
  logic [NCHAN-1:0][16:0] hr;
  logic [NCHAN:0] in_rdy, hv, pop;
  logic [NCHAN-1:0] freq, lreq, rx, lx;
  logic lk0, own0, pri0, g0, r0v, x0;
  logic [PW-1:0] ptr, lown, lg;
  logic llk, lv, lxfer;
  int j;
  assign in_f = {local_in, ring_in};
  assign {local_in_ready, ring_in_ready} = in_rdy;
  assign hr = hd[NCHAN-1:0];
  assign pop[NCHAN] = x0 & g0;
  for (genvar i = 0; i <= NCHAN; i++) begin : g_fifo
    logic [16:0] mem [BUFFER_SIZE];
    logic [AW-1:0] rp, wp;
    logic [CW-1:0] cnt;
    logic push;
    assign in_rdy[i] = ~rst & (cnt < CW'(BUFFER_SIZE));
    assign push = in_f[i][17] & in_rdy[i];
    assign hv[i] = ~rst & (cnt != '0);
    assign hd[i] = mem[rp];
    always_ff @(posedge clk)
      if (push) mem[wp] <= in_f[i][16:0];
    always_ff @(posedge clk)
      if (rst) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp == AW'(BUFFER_SIZE - 1) ? '0 : wp + 1'b1;
        if (pop[i]) rp <= rp == AW'(BUFFER_SIZE - 1) ? '0 : rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop[i]);
      end
  end
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    state_t st, rt, nst, dec;
    assign rt = (st == IDLE && hv[c]) ? dec : st;
    assign rx[c] = c == 0 ? x0 & ~g0 : freq[c] & ring_out_ready[c];
    assign lx[c] = lxfer & (lg == PW'(c));
`ifdef RING_ROUTER_MC_BROADCAST_EN
    logic sr, sl;
    assign dec = hd[c][15:0] == id ? LOCAL : hd[c][15:0] == 16'hFFFF ? BCAST : FWD;
    assign freq[c] = hv[c] & (rt == FWD | (rt == BCAST & ~sr));
    assign lreq[c] = hv[c] & (rt == LOCAL | (rt == BCAST & ~sl));
    assign pop[c] = rt == BCAST ? hv[c] & (sr | rx[c]) & (sl | lx[c]) : rx[c] | lx[c];
    always_ff @(posedge clk) begin
      sr <= ~rst & ~pop[c] & (sr | rx[c]);
      sl <= ~rst & ~pop[c] & (sl | lx[c]);
    end
`else
    assign dec = hd[c][15:0] == id ? LOCAL : FWD;
    assign freq[c] = hv[c] & (rt == FWD);
    assign lreq[c] = hv[c] & (rt == LOCAL);
    assign pop[c] = rx[c] | lx[c];
`endif
    always_comb nst = (pop[c] && hd[c][16]) ? IDLE : rt;
    always_ff @(posedge clk) st <= rst ? IDLE : nst;
  end
  always_comb begin
    g0 = lk0 ? own0 : (freq[0] & hv[NCHAN]) ? pri0 : hv[NCHAN];
    r0v = g0 ? hv[NCHAN] : freq[0];
    x0 = r0v & ring_out_ready[0];
    for (int k = 0; k < NCHAN; k++) ring_out[k] = {freq[k], hd[k]};
    ring_out[0] = {r0v, g0 ? hd[NCHAN] : hd[0]};
  end
  always_ff @(posedge clk)
    if (rst) {lk0, own0, pri0} <= '0;
    else if (x0) begin
      lk0 <= ~ring_out[0][16];
      own0 <= g0;
      pri0 <= pri0 ^ ring_out[0][16];
    end
  always_comb begin
    lg = ptr;
    j = 0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= NCHAN ? j - NCHAN : j;
      lg = lreq[PW'(j)] ? PW'(j) : lg;
    end
    lg = llk ? lown : lg;
    lv = lreq[lg];
    lxfer = lv & local_out_ready;
    local_out = {lv, hr[lg]};
  end
  always_ff @(posedge clk)
    if (rst) {llk, lown, ptr} <= '0;
    else if (lxfer) begin
      llk <= ~local_out[16];
      lown <= lg;
      if (local_out[16]) ptr <= lg == PW'(NCHAN - 1) ? '0 : lg + 1'b1;
    end
endmodule

// File: tb/tb_ring_router_mc.sv
// tb_ring_router_mc: scoreboard bench for ring_router_mc with NCHAN=3, id=3
module tb_ring_router_mc;
  localparam int NC = 3;
  logic clk = 0, rst = 1;
  logic [NC-1:0][17:0] rin = '0, rout;
  logic [NC-1:0] rin_rdy, rordy = '1;
  logic [17:0] lin = '0, lout;
  logic lin_rdy, lordy = 1'b1;
  logic [16:0] src [NC+1][$];
  logic [16:0] exp_r [NC][$];
  logic [16:0] exp_l [$];
  logic [NC:0] fire = '0;
  logic [4:0] pat;
  logic orv;
  int checks = 0, errs = 0;
  always #5 clk = ~clk;
  ring_router_mc #(.NCHAN(NC), .BUFFER_SIZE(4)) dut (
    .clk(clk), .rst(rst), .id(16'd3),
    .ring_in(rin), .ring_in_ready(rin_rdy),
    .ring_out(rout), .ring_out_ready(rordy),
    .local_in(lin), .local_in_ready(lin_rdy),
    .local_out(lout), .local_out_ready(lordy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask
  task automatic send(input int ch, input int n, input logic [15:0] dest, input logic [15:0] base, input int tgt);
    for (int i = 0; i < n; i++) begin
      logic [16:0] f;
      f = {i == n - 1, i == 0 ? dest : base + 16'(i)};
      src[ch].push_back(f);
      if (tgt < NC) exp_r[tgt].push_back(f);
      if (tgt == NC || tgt == NC + 1) exp_l.push_back(f);
      if (tgt == NC + 1) exp_r[ch].push_back(f);
    end
  endtask
  function automatic bit busy();
    for (int i = 0; i <= NC; i++) if (src[i].size() > 0) return 1;
    for (int i = 0; i < NC; i++) if (exp_r[i].size() > 0) return 1;
    return exp_l.size() > 0;
  endfunction
  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy() && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 500), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    #2;
    for (int i = 0; i <= NC; i++) if (fire[i] && src[i].size() > 0) void'(src[i].pop_front());
    for (int i = 0; i < NC; i++) rin[i] = src[i].size() > 0 ? {1'b1, src[i][0]} : 18'd0;
    lin = src[NC].size() > 0 ? {1'b1, src[NC][0]} : 18'd0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) fire[i] = rin[i][17] & rin_rdy[i];
    fire[NC] = lin[17] & lin_rdy;
    for (int c = 0; c < NC; c++)
      if (rout[c][17] && rordy[c]) begin
        if (exp_r[c].size() == 0) begin
          checks++;
          errs++;
          $display("FAIL ring_out%0d_extra: got %h, required nothing", c, rout[c][16:0]);
        end else chk($sformatf("ring_out%0d", c), 32'(rout[c][16:0]), 32'(exp_r[c].pop_front()));
      end
    if (lout[17] && lordy) begin
      if (exp_l.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL local_out_extra: got %h, required nothing", lout[16:0]);
      end else chk("local_out", 32'(lout[16:0]), 32'(exp_l.pop_front()));
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {lin_rdy, rin_rdy}, 0);
    chk("reset_valid", {lout[17], rout[2][17], rout[1][17], rout[0][17]}, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_reset", {lin_rdy, rin_rdy}, 4'hF);
    @(posedge clk);
    #1;
    send(0, 4, 16'd9, 16'h9000, 0);
    send(NC, 2, 16'd7, 16'h7000, 0);
    wait_idle("arb0");
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NC; c++) send(c, 2, 16'd3, 16'hA000 + 16'(c * 16 + p), NC);
    wait_idle("rr");
    send(1, 3, 16'd3, 16'h1000, NC);
    orv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat[i] = lout[17];
      orv |= rout[1][17];
    end
    chk("extract_timing", 32'(pat), 5'b01110);
    chk("extract_ring1_idle", 32'(orv), 0);
    wait_idle("extract");
    rordy[0] = 0;
    send(0, 4, 16'd9, 16'hB000, 0);
    send(1, 2, 16'd9, 16'hC000, 1);
    repeat (8) @(negedge clk);
    chk("full_ready", {lin_rdy, rin_rdy}, 4'b1110);
    @(posedge clk);
    #1 rordy[0] = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat[i] = rout[0][17];
    end
    chk("drain_burst", 32'(pat), 5'b01111);
    wait_idle("full");
    rordy[1] = 0;
    send(1, 5, 16'd9, 16'h5000, NC + 2);
    exp_r[1].push_back({1'b0, 16'd9});
    exp_r[1].push_back({1'b0, 16'h5001});
    repeat (6) @(posedge clk);
    #1 rordy[1] = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1;
    src[1].delete();
    @(negedge clk);
    chk("rst_valid", {lout[17], rout[2][17], rout[1][17], rout[0][17]}, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_valid", {lout[17], rout[2][17], rout[1][17], rout[0][17]}, 0);
    chk("post_rst_ready", {lin_rdy, rin_rdy}, 4'hF);
    @(posedge clk);
    #1;
    send(1, 2, 16'd3, 16'hD000, NC);
    send(2, 3, 16'd9, 16'hE000, 2);
    wait_idle("reset_mid");
`ifdef RING_ROUTER_MC_BROADCAST_EN
    lordy = 0;
    send(1, 3, 16'hFFFF, 16'hF000, NC + 1);
    repeat (3) @(posedge clk);
    #1 lordy = 1;
`else
    send(1, 3, 16'hFFFF, 16'hF000, 1);
`endif
    wait_idle("bcast");
    chk("left_local", exp_l.size(), 0);
    for (int c = 0; c < NC; c++) chk($sformatf("left_ring%0d", c), exp_r[c].size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
